// File: rtl/raster_zstage.sv
// raster_zstage: depth-test and write-back stage at the tail of the raster pipeline.
//
// Fragments arrive through a valid/ready handshake (S0), the stored depth is
// read from the Z buffer and compared with the selected depth function (S1), and
// passing fragments appear on the registered colour/Z write port (S2).  The block
// also runs the framebuffer clear sweep and forwards in-flight writes so that
// back-to-back fragments to one pixel test against current data.
//
// Optional feature: define RASTER_ZFLOAT_EN to compare Z as a sign-magnitude
// float instead of an unsigned integer.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   frag_valid / frag_ready     fragment handshake
//   frag_addr/_z/_color         fragment pixel address, depth, colour
//   depth_func, z_write         depth function and Z write enable (per fragment)
//   clear_start, clear_busy     clear request pulse, clear pending/sweeping
//   zbuf_rden/_raddr/_rdata     Z buffer read port (data one cycle after rden)
//   fb_wren/_zen/_waddr/_wcolor/_wz  combined colour/Z write port
//   frag_passed                 pulse per passing fragment, aligned with fb_wren
module raster_zstage #(
    parameter int unsigned     ZW          = 18,
    parameter int unsigned     CW          = 16,
    parameter int unsigned     AW          = 19,
    parameter int unsigned     DEPTH       = 307200,
    parameter logic [ZW-1:0]   CLEAR_Z     = '0,
    parameter logic [CW-1:0]   CLEAR_COLOR = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frag_valid,
    output logic          frag_ready,
    input  logic [AW-1:0] frag_addr,
    input  logic [ZW-1:0] frag_z,
    input  logic [CW-1:0] frag_color,
    input  logic [1:0]    depth_func,
    input  logic          z_write,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          zbuf_rden,
    output logic [AW-1:0] zbuf_raddr,
    input  logic [ZW-1:0] zbuf_rdata,
    output logic          fb_wren,
    output logic          fb_zen,
    output logic [AW-1:0] fb_waddr,
    output logic [CW-1:0] fb_wcolor,
    output logic [ZW-1:0] fb_wz,
    output logic          frag_passed
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } stateT;

    localparam logic [1:0] FUNC_GREATER = 2'b00;
    localparam logic [1:0] FUNC_GEQUAL  = 2'b01;
    localparam logic [1:0] FUNC_LESS    = 2'b10;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    stateT         state, stateNext;
    logic [AW-1:0] clearCnt;
    logic [AW-1:0] clearAddr;
    logic          loadClear;
    logic          flushHist;
    logic          accept;

    logic          s1Valid;
    logic [AW-1:0] s1Addr;
    logic [ZW-1:0] s1Z;
    logic [CW-1:0] s1Color;
    logic [1:0]    s1Func;
    logic          s1ZWrite;

    logic          prevValid;
    logic [AW-1:0] prevAddr;
    logic [ZW-1:0] prevZ;

    logic [ZW-1:0] storedZ;
    logic [ZW-1:0] fragKey;
    logic [ZW-1:0] storedKey;
    logic          depthPass;

`ifdef RASTER_ZFLOAT_EN
    // Monotonic key: negatives invert all bits, positives invert the sign bit.
    // Both zeros map to the +0 key so that +0 and -0 compare equal.
    function automatic logic [ZW-1:0] zKey(input logic [ZW-1:0] z);
        if (z[ZW-2:0] == '0)
            return {1'b1, {(ZW-1){1'b0}}};
        else if (z[ZW-1])
            return ~z;
        else
            return {1'b1, z[ZW-2:0]};
    endfunction
`else
    function automatic logic [ZW-1:0] zKey(input logic [ZW-1:0] z);
        return z;
    endfunction
`endif

    // ---------------------------------------------------------------- S0
    // Ready is held low while reset is asserted even though the state
    // register already sits in IDLE.
    assign accept     = frag_valid & frag_ready;
    assign zbuf_rden  = accept;
    assign zbuf_raddr = reset ? '0 : frag_addr;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= stateNext;
    end

    // clearCnt always equals the address currently shown on fb_waddr during
    // CLEAR, so the write for the next address is loaded one cycle ahead.
    always_comb begin
        stateNext  = state;
        loadClear  = 1'b0;
        clearAddr  = '0;
        frag_ready = 1'b0;
        clear_busy = 1'b0;
        unique case (state)
            IDLE: begin
                frag_ready = ~reset;
                if (clear_start)
                    stateNext = DRAIN;
            end
            DRAIN: begin
                clear_busy = 1'b1;
                if (!s1Valid && !fb_wren) begin
                    stateNext = CLEAR;
                    loadClear = 1'b1;
                end
            end
            CLEAR: begin
                clear_busy = 1'b1;
                if (clearCnt == LAST_ADDR) begin
                    stateNext = IDLE;
                end else begin
                    loadClear = 1'b1;
                    clearAddr = clearCnt + AW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign flushHist = (state == CLEAR) && (stateNext == IDLE);

    // ---------------------------------------------------------------- S1
    // Newest matching write wins: S2 registers, then last cycle's write,
    // then the Z buffer (which returns pre-write data on a collision).
    always_comb begin
        storedZ = zbuf_rdata;
        if (fb_wren && fb_zen && (fb_waddr == s1Addr))
            storedZ = fb_wz;
        else if (prevValid && (prevAddr == s1Addr))
            storedZ = prevZ;
    end

    always_comb begin
        fragKey   = zKey(s1Z);
        storedKey = zKey(storedZ);
        unique case (s1Func)
            FUNC_GREATER: depthPass = fragKey >  storedKey;
            FUNC_GEQUAL:  depthPass = fragKey >= storedKey;
            FUNC_LESS:    depthPass = fragKey <  storedKey;
            default:      depthPass = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid     <= 1'b0;
            s1Addr      <= '0;
            s1Z         <= '0;
            s1Color     <= '0;
            s1Func      <= '0;
            s1ZWrite    <= 1'b0;
            clearCnt    <= '0;
            prevValid   <= 1'b0;
            prevAddr    <= '0;
            prevZ       <= '0;
            fb_wren     <= 1'b0;
            fb_zen      <= 1'b0;
            fb_waddr    <= '0;
            fb_wcolor   <= '0;
            fb_wz       <= '0;
            frag_passed <= 1'b0;
        end else begin
            s1Valid <= accept;
            if (accept) begin
                s1Addr   <= frag_addr;
                s1Z      <= frag_z;
                s1Color  <= frag_color;
                s1Func   <= depth_func;
                s1ZWrite <= z_write;
            end

            clearCnt <= loadClear ? clearAddr : '0;

            prevValid <= fb_wren & fb_zen & ~flushHist;
            prevAddr  <= fb_waddr;
            prevZ     <= fb_wz;

            if (loadClear) begin
                fb_wren     <= 1'b1;
                fb_zen      <= 1'b1;
                fb_waddr    <= clearAddr;
                fb_wcolor   <= CLEAR_COLOR;
                fb_wz       <= CLEAR_Z;
                frag_passed <= 1'b0;
            end else if (s1Valid && depthPass) begin
                fb_wren     <= 1'b1;
                fb_zen      <= s1ZWrite;
                fb_waddr    <= s1Addr;
                fb_wcolor   <= s1Color;
                fb_wz       <= s1Z;
                frag_passed <= 1'b1;
            end else begin
                fb_wren     <= 1'b0;
                fb_zen      <= 1'b0;
                frag_passed <= 1'b0;
            end
        end
    end

endmodule

// File: doc/raster_zstage.md
# raster_zstage

Parametrised depth-test and write-back stage at the tail of the raster pipeline. It takes shaded fragments through a valid/ready handshake, reads the stored depth from the Z buffer, and applies a selectable depth function. Passing fragments are written to the combined colour/Z write port. The block also owns the hardware framebuffer clear sweep and forwards in-flight writes so back-to-back fragments to the same pixel test against current data.

## Interface
Parameters:
- ZW, 18: depth word width.
- CW, 16: colour word width.
- AW, 19: pixel address width.
- DEPTH, 307200: pixel count swept by clear; addresses 0..DEPTH-1.
- CLEAR_Z, 0: depth value written by clear.
- CLEAR_COLOR, 0: colour value written by clear.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- frag_valid  in  1  fragment present.
- frag_ready  out  1  stage accepts a fragment this cycle.
- frag_addr  in  AW  pixel address.
- frag_z  in  ZW  fragment depth.
- frag_color  in  CW  fragment colour.
- depth_func  in  2  00 GREATER, 01 GEQUAL, 10 LESS, 11 ALWAYS; sampled at acceptance.
- z_write  in  1  1 = passing fragment also updates Z; sampled at acceptance.
- clear_start  in  1  single-cycle request to clear the whole framebuffer.
- clear_busy  out  1  clear pending or sweeping.
- zbuf_rden  out  1  Z read strobe.
- zbuf_raddr  out  AW  Z read address.
- zbuf_rdata  in  ZW  Z read data; valid exactly one cycle after zbuf_rden; read-during-write returns old data.
- fb_wren  out  1  write strobe.
- fb_zen  out  1  Z lane enable (colour lane always written when fb_wren).
- fb_waddr  out  AW  write address.
- fb_wcolor  out  CW  write colour.
- fb_wz  out  ZW  write depth.
- frag_passed  out  1  one-cycle pulse per fragment that passed (coincides with its fb_wren).

## Operation
- Pipeline: S0 accept/read issue, S1 compare, S2 registered write outputs. Throughput is one fragment per cycle.
- S0: a fragment is accepted on frag_valid & frag_ready. zbuf_rden = frag_valid & frag_ready, and zbuf_raddr = frag_addr, both combinational. addr, z, color, depth_func and z_write are registered into S1.
- S1: stored Z is selected from:
  - the current S2 write registers, if fb_wren & fb_zen & address match;
  - else the previous-cycle write, if it had Z enabled and its address matches;
  - else zbuf_rdata.
  - The newest match wins.
- Depth test (frag_z vs stored Z): GREATER passes when >, GEQUAL when >=, LESS when <, ALWAYS always.
- Pass: S2 registers fb_wren=1, fb_zen=z_write, addr, color and z, and raises frag_passed. Fail: fb_wren=0 and nothing is written.
- FSM states IDLE, DRAIN, CLEAR:
  - IDLE: frag_ready=1. clear_start moves to DRAIN.
  - DRAIN: frag_ready=0. Moves to CLEAR once S1 and S2 are empty.
  - CLEAR: 19-bit counter from 0. Each cycle writes fb_wren=1, fb_zen=1, CLEAR_COLOR, CLEAR_Z at the counter address. After address DEPTH-1 returns to IDLE and the counter wraps to 0.
- clear_busy=1 in DRAIN and CLEAR.
- clear_start while not IDLE is ignored. clear_start coincident with frag_valid in IDLE accepts that fragment; it drains before the sweep.
- Clear writes are forwarding sources like any write. The forwarding history is flushed on the return to IDLE.

## Timing
- Reset values:
  - frag_ready=0 while reset is high, 1 on the first cycle after release.
  - clear_busy=0, zbuf_rden=0, fb_wren=0, fb_zen=0, frag_passed=0.
  - All address and data outputs 0.
  - FSM in IDLE, pipeline valids 0, forwarding history invalid.
- Latency: fragment accepted at cycle t → write visible on the fb_* ports at t+2.
- Clear: clear_start at t with an empty pipeline → DRAIN at t+1, first clear write at t+2, last at t+DEPTH+1, frag_ready=1 at t+DEPTH+2.
- Reset mid-sweep or mid-pipeline aborts immediately. There are no partial writes after reset asserts.

## Configuration
- RASTER_ZFLOAT_EN defined: Z is compared as sign-magnitude float (MSB sign, then exponent, then mantissa). Both operands are mapped to a monotonic key (negative: invert all bits; positive: invert the sign bit) before an unsigned compare. +0 and -0 compare equal.
- Undefined: Z is compared as unsigned integers. The mapping logic is absent.

## Test plan
- Reset, Z buffer holding 100 at addr 5; fragment addr 5, z=200, GREATER → fb_wren=1 at t+2, fb_waddr=5, fb_wz=200, frag_passed=1.
- Same setup, z=50, GREATER → fb_wren=0 at t+2; with LESS → written; with ALWAYS and z_write=0 → fb_wren=1, fb_zen=0.
- Back-to-back fragments at addr 9 on t, t+1, t+2, z=10, 20, 15, GREATER, stored 0 → writes of 10 and 20 only; the third fails against forwarded 20.
- clear_start with a fragment in S1, DEPTH=8 → that fragment's write completes; clear writes addresses 0..7 with CLEAR_Z/CLEAR_COLOR; clear_busy high throughout; frag_ready returns 1 after the address-7 write.
- Reset asserted at clear address 3 → all outputs 0 asynchronously; after release frag_ready=1, no further clear writes.
- With RASTER_ZFLOAT_EN, stored Z = -1.0, fragment +0.5, GREATER → passes; stored +0, fragment -0, GEQUAL → passes.
